// File: rtl/prog_seq_counter.sv
// prog_seq_counter: programmable table-driven sequence counter with direction, load, length and wrap strobe
module prog_seq_counter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int LEN_W = $clog2(DEPTH + 1),
    parameter logic [DEPTH*WIDTH-1:0] INIT_SEQ = {4'hF, 4'hD, 4'hC, 4'h8}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             len_wr,
    input  logic [LEN_W-1:0] len_val,
    output logic [WIDTH-1:0] q,
    output logic [IDX_W-1:0] idx,
    output logic             wrap
);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [WIDTH-1:0] code_q, code_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             wrap_q, wrap_d;
    logic             len_ok, wr_ok;

    assign len_ok = len_wr && len_val != '0 && len_val <= DEPTH_L;
    assign wr_ok  = wr_en && LEN_W'(wr_addr) < DEPTH_L;

    // next index/length/wrap by priority len_wr > load > en; q forwards a same-cycle write to the new index
    always_comb begin
        idx_d  = idx_q;
        len_d  = len_q;
        wrap_d = 1'b0;
        if (len_ok) begin
            len_d = len_val;
            idx_d = (LEN_W'(idx_q) >= len_val) ? '0 : idx_q;
        end else if (load) begin
            idx_d = (LEN_W'(load_idx) < len_q) ? load_idx : '0;
        end else if (en) begin
            wrap_d = dir ? (idx_q == '0) : (LEN_W'(idx_q) == len_q - 1'b1);
            idx_d  = wrap_d ? (dir ? IDX_W'(len_q - 1'b1) : '0)
                            : (dir ? idx_q - 1'b1 : idx_q + 1'b1);
        end
        code_d = (wr_ok && wr_addr == idx_d) ? wr_data : tbl_q[idx_d];
    end

    // state registers and table storage; clr restores the initial table and full length
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= INIT_SEQ[i*WIDTH +: WIDTH];
            len_q  <= DEPTH_L;
            idx_q  <= '0;
            code_q <= INIT_SEQ[WIDTH-1:0];
            wrap_q <= 1'b0;
        end else begin
            if (wr_ok) tbl_q[wr_addr] <= wr_data;
            len_q  <= len_d;
            idx_q  <= idx_d;
            code_q <= code_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = code_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_prog_seq_counter.sv
// tb_prog_seq_counter: randomized and directed check of prog_seq_counter against an array-based model
module tb_prog_seq_counter;
    logic       clk = 1'b0;
    logic       clr = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0, wr_en = 1'b0, len_wr = 1'b0;
    logic [1:0] load_idx = '0, wr_addr = '0, idx;
    logic [3:0] wr_data = '0, q;
    logic [2:0] len_val = '0;
    logic       wrap;

    int n_chk = 0, n_fail = 0;
    int m_tbl [4];
    int m_len = 4, m_idx = 0, m_wrap = 0;
    int init_tbl [4] = '{8, 12, 13, 15};

    prog_seq_counter dut (
        .clk(clk), .clr(clr), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .len_wr(len_wr),
        .len_val(len_val), .q(q), .idx(idx), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: operates on plain integers after each rising edge
    task automatic model();
        int w;
        if (clr) begin
            m_tbl = init_tbl;
            m_len = 4;
            m_idx = 0;
            m_wrap = 0;
        end else begin
            w = 0;
            if (len_wr && len_val >= 1 && len_val <= 4) begin
                m_len = len_val;
                if (m_idx >= m_len) m_idx = 0;
            end else if (load) begin
                m_idx = (load_idx < m_len) ? int'(load_idx) : 0;
            end else if (en) begin
                if (!dir) begin
                    w = (m_idx == m_len - 1);
                    m_idx = (m_idx + 1) % m_len;
                end else begin
                    w = (m_idx == 0);
                    m_idx = (m_idx + m_len - 1) % m_len;
                end
            end
            if (wr_en) m_tbl[wr_addr] = wr_data;
            m_wrap = w;
        end
    endtask

    task automatic cyc(input bit c, input bit e, input bit d, input bit l, input int li,
                       input bit w, input int wa, input int wd, input bit lw, input int lv);
        @(negedge clk);
        clr = c; en = e; dir = d; load = l; load_idx = li[1:0];
        wr_en = w; wr_addr = wa[1:0]; wr_data = wd[3:0]; len_wr = lw; len_val = lv[2:0];
        @(posedge clk);
        model();
        #1;
        check("q", q, m_tbl[m_idx]);
        check("idx", idx, m_idx);
        check("wrap", wrap, m_wrap);
    endtask

    task automatic rst();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step(input bit d);
        cyc(0, 1, d, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int up_q [9] = '{12, 13, 15, 8, 12, 13, 15, 8, 12};
        int dn_q [4] = '{15, 13, 12, 8};
        int sh_i [3] = '{1, 0, 1};
        m_tbl = init_tbl;
        // 1: reset and default up run
        rst();
        check("rst_q", q, 8);
        check("rst_idx", idx, 0);
        check("rst_wrap", wrap, 0);
        for (int i = 0; i < 9; i++) begin
            step(0);
            check("t1_q", q, up_q[i]);
            check("t1_idx", idx, (i + 1) % 4);
            check("t1_wrap", wrap, up_q[i] == 8);
        end
        // 2: down count
        rst();
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t2_q", q, dn_q[i]);
            check("t2_wrap", wrap, i == 0);
        end
        // 3: program table and length, invalid lengths ignored
        rst();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, i, 1 << i, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 3);
        check("t3_len_q", q, 1);
        for (int i = 0; i < 3; i++) begin
            step(0);
            check("t3_run_q", q, (i == 2) ? 1 : (2 << i));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        step(0); step(0); step(0);
        check("t3_len_kept_idx", idx, 0);
        check("t3_len_kept_wrap", wrap, 1);
        // 4: length shrink clamp
        rst();
        step(0); step(0); step(0);
        check("t4_at3", idx, 3);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 2);
        check("t4_clamp_idx", idx, 0);
        check("t4_clamp_wrap", wrap, 0);
        for (int i = 0; i < 3; i++) begin
            step(0);
            check("t4_idx", idx, sh_i[i]);
        end
        // 4b: length 1 wraps every step
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(i[0]);
            check("len1_wrap", wrap, 1);
            check("len1_idx", idx, 0);
        end
        // 5: load and write forwarding
        rst();
        cyc(0, 1, 0, 1, 2, 0, 0, 0, 0, 0);
        check("t5_load_idx", idx, 2);
        check("t5_load_q", q, 13);
        check("t5_load_wrap", wrap, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 2, 10, 0, 0);
        check("t5_fwd_q", q, 10);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        cyc(0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        check("t5_load_oob", idx, 0);
        // 6: reset mid-operation
        rst();
        step(0); step(0);
        cyc(1, 1, 0, 0, 0, 1, 1, 3, 1, 2);
        check("t6_idx", idx, 0);
        check("t6_q", q, 8);
        check("t6_wrap", wrap, 0);
        for (int i = 0; i < 3; i++) begin
            step(0);
            check("t6_tbl", q, init_tbl[i + 1]);
        end
        // random traffic
        rst();
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 9) == 0,
                $urandom_range(0, 7));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_seq_counter.md
Name: prog_seq_counter

Overview:
Parameterised programmable sequence counter. It steps through a table of up to DEPTH codes, each WIDTH bits wide. The table is reset-initialised from INIT_SEQ, is rewritable at run time, and has a programmable active length. Over the fixed 4-code generator it adds:
- up/down direction
- count enable
- index load
- table and length programming
- a wrap strobe

It sits beside the other counters in the lab datapath and drives display or stimulus logic.

Parameters:
WIDTH, 4, bits per sequence code.
DEPTH, 4, number of table entries (≥2).
IDX_W, $clog2(DEPTH), index width.
LEN_W, $clog2(DEPTH+1), length field width.
INIT_SEQ, {4'hF,4'hD,4'hC,4'h8}, reset table contents as a packed vector; entry i is at bits [i*WIDTH +: WIDTH], so entry 0 = 4'h8.

Ports:
clk  in  1  rising-edge clock.
clr  in  1  synchronous, active-high reset.
en  in  1  advance one step per cycle while high.
dir  in  1  0 = up (idx+1), 1 = down (idx-1).
load  in  1  jump to load_idx.
load_idx  in  IDX_W  target index for load.
wr_en  in  1  write a table entry.
wr_addr  in  IDX_W  table entry address.
wr_data  in  WIDTH  table entry data.
len_wr  in  1  write the active length.
len_val  in  LEN_W  new length; legal range 1..DEPTH.
q  out  WIDTH  registered code, always equal to table[idx].
idx  out  IDX_W  registered current index.
wrap  out  1  registered one-cycle pulse on a sequence wrap.

Behaviour:
- All state is updated on the rising edge of clk; there is no asynchronous path.
- Reset (clr=1 at an edge):
  - table ← INIT_SEQ, len ← DEPTH, idx ← 0, q ← INIT_SEQ entry 0, wrap ← 0.
  - clr overrides every other input, including mid-sequence and mid-write.
- Control priority per cycle: clr > len_wr > load > en. A lower-priority action is ignored in a cycle where a higher one occurs, except wr_en (see below).
- len_wr:
  - len_val of 0 or >DEPTH is ignored entirely.
  - Otherwise len ← len_val, and no step happens that cycle.
  - If the current idx ≥ len_val, idx ← 0.
  - A load in the same cycle is ignored.
- load:
  - idx ← load_idx if load_idx < len; otherwise idx ← 0.
  - wrap stays 0.
- en step, up (dir=0): idx ← (idx == len-1) ? 0 : idx+1; wrap=1 when the 0 branch is taken.
- en step, down (dir=1): idx ← (idx == 0) ? len-1 : idx-1; wrap=1 when idx was 0.
- en=0 with no other control: hold idx and q; wrap=0.
- wrap is high for exactly one cycle per wrap.
- When len=1, every en step wraps, so wrap stays high continuously and idx stays 0.
- wr_en:
  - Processed in parallel with the controls above: table[wr_addr] ← wr_data.
  - Ignored if clr is high.
  - wr_addr ≥ DEPTH is ignored.
  - Writes outside the active length are permitted and stored.
- q ← table[next idx] with write-forwarding: if wr_en targets the next idx in the same cycle, q ← wr_data. q therefore never shows a stale table value.
- Latency: one cycle from an en/load/len_wr edge to the updated idx/q/wrap.

Test Plan:
1. Reset and default run: clr=1 for 2 cycles, then en=1, dir=0 for 9 cycles → q = 8,C,D,F,8,C,D,F,8,C. wrap is high on the cycles where q returns to 8; idx follows 0,1,2,3,0…
2. Down count: after reset, en=1, dir=1 → q = 8,F,D,C,8. wrap pulses on the 8→F transition.
3. Program the table and length (WIDTH=4, DEPTH=4):
   - Write entries 0..2 = 1,2,4, then len_wr with len_val=3, then run up → q cycles 1,2,4,1.
   - len_val=0 and len_val=5 are both ignored; len stays 3.
4. Length shrink clamp: at idx=3 with len=4, apply len_wr with len_val=2 and en=1 → next idx=0 with no step, wrap=0. Following steps give idx 1,0,1.
5. Load and forwarding:
   - load with load_idx=2 → idx=2, q=D.
   - With en=1 at idx=1, also write wr_addr=2, wr_data=A → next q=A.
   - load_idx=3 with len=2 → idx=0.
6. Reset mid-operation: at idx=2 with en, wr_en, and len_wr all high, assert clr → next cycle idx=0, q=8, len=4, table back to INIT_SEQ, wrap=0.
